// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM emulation slave.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_MACK
  } i2c_state_e;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'b1010000;
  localparam int         I2C_MEM_DEPTH        = 256;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop for one bus line.
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] ff_q;

  // Reset to the idle bus level so no edge is reported when reset releases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {3{RST_VAL}};
    end else begin
      ff_q <= {ff_q[1:0], d_i};
    end
  end

  assign level_o = ff_q[1];
  assign rise_o  = ff_q[1] & ~ff_q[2];
  assign fall_o  = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 256-byte serial EEPROM, oversampling SCL/SDA on clk_i.
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] ADDRESS   = I2C_DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = I2C_MEM_DEPTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_oe_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_scl (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_sda (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic bus_start, bus_stop;
  assign bus_start = sda_fall & scl_lvl;
  assign bus_stop  = sda_rise & scl_lvl;

  i2c_state_e  state_q;
  logic [7:0]  ptr_q;
  logic [7:0]  sr_q;
  logic [3:0]  bit_cnt_q;
  logic        rw_q;
  logic        sda_oe_q;

  logic [7:0]  mem_q [MEM_DEPTH];
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  sr_d;
  logic [7:0]  ptr_d;
  logic        byte_done;

  assign sr_d      = {sr_q[6:0], sda_lvl};
  assign ptr_d     = ptr_q + 8'd1;
  assign mem_rdata = mem_q[ptr_q];
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  // Must mirror the FSM priority: START/STOP abort the byte before it is stored.
  assign mem_we = (state_q == ST_WR_DATA) && byte_done && !bus_start && !bus_stop;

  // Storage is deliberately outside the reset domain so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ptr_q] <= sr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 8'h00;
      sr_q      <= 8'h00;
      bit_cnt_q <= 4'd0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (bus_start) begin
      state_q   <= ST_DEV_ADDR;
      bit_cnt_q <= 4'd0;
      sda_oe_q  <= 1'b0;
    end else if (bus_stop) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      sda_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end

        ST_DEV_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            if (sr_q[7:1] == ADDRESS) begin
              rw_q     <= sr_q[0];
              sda_oe_q <= 1'b1;
              state_q  <= ST_DEV_ACK;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        ST_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_q <= 4'd0;
            if (rw_q) begin
              // First read bit goes out on the same edge that ends the ACK.
              sr_q     <= {mem_rdata[6:0], 1'b0};
              sda_oe_q <= ~mem_rdata[7];
              state_q  <= ST_RD_DATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WORD_ADDR;
            end
          end
        end

        ST_WORD_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            ptr_q    <= sr_q;
            sda_oe_q <= 1'b1;
            state_q  <= ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
            state_q   <= ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            ptr_q    <= ptr_d;
            sda_oe_q <= 1'b1;
            state_q  <= ST_WR_ACK;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            sda_oe_q  <= 1'b0;
            ptr_q     <= ptr_d;
            bit_cnt_q <= 4'd0;
            state_q   <= ST_RD_MACK;
          end else if (scl_fall) begin
            sda_oe_q <= ~sr_q[7];
            sr_q     <= {sr_q[6:0], 1'b0};
          end
        end

        ST_RD_MACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              sr_q      <= mem_rdata;
              bit_cnt_q <= 4'd0;
              state_q   <= ST_RD_DATA;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oe_o = sda_oe_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Self-checking bench: bit-banged I2C master at clk/8 against a byte-array EEPROM model.
module tb_i2c_eeprom_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_o;
  logic sda_oe;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave #(.ADDRESS(7'b1010000), .MEM_DEPTH(256)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_o   (sda_o),
    .sda_oe_o(sda_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [256];
  int         ref_ptr = 0;
  logic [7:0] wbuf [300];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every slave-driven SDA change must happen while SCL is low.
  always @(sda_oe) begin
    if (rst_n && $time > 0) chk("oe_change_scl_low", {31'd0, scl}, 32'd0);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;  wait_clk(2);
    scl = 1'b1; wait_clk(2);
    r = sda_bus; wait_clk(2);
    scl = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(2);
    scl = 1'b1;   wait_clk(2);
    sda_m = 1'b0; wait_clk(2);
    scl = 1'b0;   wait_clk(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(2);
    scl = 1'b1;   wait_clk(2);
    sda_m = 1'b1; wait_clk(4);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic op_write(input logic [7:0] addr, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack); chk("wr_dev_ack", {31'd0, ack}, 32'd1);
    wr_byte(addr, ack);  chk("wr_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], ack); chk("wr_data_ack", {31'd0, ack}, 32'd1);
    end
    i2c_stop();
    for (int i = 0; i < n; i++) ref_mem[(addr + i) % 256] = wbuf[i];
    ref_ptr = (addr + n) % 256;
  endtask

  task automatic read_burst(input int n, input string tag);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      chk(tag, {24'd0, d}, {24'd0, ref_mem[ref_ptr]});
      ref_ptr = (ref_ptr + 1) % 256;
    end
  endtask

  task automatic op_rand_read(input logic [7:0] addr, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack); chk("rr_dev_ack", {31'd0, ack}, 32'd1);
    wr_byte(addr, ack);  chk("rr_addr_ack", {31'd0, ack}, 32'd1);
    i2c_start();
    wr_byte(8'hA1, ack); chk("rr_rd_ack", {31'd0, ack}, 32'd1);
    ref_ptr = addr;
    read_burst(n, "rand_read_data");
    i2c_stop();
  endtask

  task automatic op_cur_read(input int n);
    logic ack;
    i2c_start();
    wr_byte(8'hA1, ack); chk("cr_dev_ack", {31'd0, ack}, 32'd1);
    read_burst(n, "cur_read_data");
    i2c_stop();
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         op, n;
    logic [7:0] addr;

    wait_clk(5);
    chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("reset_sda_o", {31'd0, sda_o}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Fill the whole array in one page write that wraps back to 0x00.
    for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
    op_write(8'h00, 256);
    op_cur_read(2);

    // Byte write then random read.
    wbuf[0] = 8'h5A;
    op_write(8'h10, 1);
    op_rand_read(8'h10, 1);
    chk("byte_write_5a", {24'd0, ref_mem[8'h10]}, 32'h5A);

    // Sequential write across the top of the array.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    op_write(8'hFE, 3);
    op_rand_read(8'hFE, 3);
    op_cur_read(1);

    // Wrong device address: NACK and nothing that follows is acted on.
    i2c_start();
    wr_byte(8'hA2, ack); chk("wrong_addr_nack", {31'd0, ack}, 32'd0);
    wr_byte(8'h10, ack); chk("wrong_addr_ign1", {31'd0, ack}, 32'd0);
    wr_byte(8'h77, ack); chk("wrong_addr_ign2", {31'd0, ack}, 32'd0);
    i2c_stop();
    op_rand_read(8'h10, 1);

    // Master NACK ends a read; the slave stays silent afterwards.
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h10, ack);
    i2c_start();
    wr_byte(8'hA1, ack);
    ref_ptr = 8'h10;
    read_burst(2, "nack_read_data");
    rd_byte(1'b1, d);
    chk("after_nack_silent", {24'd0, d}, 32'hFF);
    i2c_stop();
    chk("after_nack_ptr_model", ref_ptr, 32'h12);
    op_cur_read(1);

    // STOP in the middle of a data byte.
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h40, ack);
    ref_ptr = 8'h40;
    for (int i = 7; i >= 4; i--) bit_xfer(i[0], r);
    i2c_stop();
    chk("mid_stop_oe", {31'd0, sda_oe}, 32'd0);
    op_rand_read(8'h40, 1);

    // Reset while the slave drives the device-address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(i == 7 || i == 5, r);
    sda_m = 1'b1; wait_clk(2);
    scl = 1'b1;   wait_clk(1);
    chk("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("reset_async_release", {31'd0, sda_oe}, 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    scl = 1'b0; wait_clk(2);
    i2c_stop();
    ref_ptr = 0;
    op_cur_read(2);

    // Randomized mix of transactions.
    for (int t = 0; t < 30; t++) begin
      op   = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      addr = 8'($urandom);
      if (op == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        op_write(addr, n);
      end else if (op == 1) begin
        op_rand_read(addr, n);
      end else begin
        op_cur_read(n);
      end
    end

    wait_clk(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
Synthesizable I2C slave that emulates a 256-byte serial EEPROM. It sits on the board-level I2C bus next to the SoC's I2C master and responds at a fixed 7-bit device address. SCL and SDA are oversampled by a single system clock. Byte write, page (sequential) write, current-address read, random read and sequential read are supported.

Parameters:
ADDRESS, 7'b1010000, 7-bit I2C device address the slave acknowledges.
MEM_DEPTH, 256, bytes of storage; fixed at 256 so the word address is exactly 8 bits.

Ports:
clk_i  in  1  system clock; must be at least 8x the SCL frequency.
rst_ni  in  1  asynchronous active-low reset.
scl_i  in  1  SCL pad input; the slave never stretches the clock.
sda_i  in  1  SDA pad input.
sda_o  out  1  SDA output value; constant 0 (open-drain).
sda_oe_o  out  1  1 = pull SDA low; 0 = release the line.

Interface: one clock; reset is asynchronous and active-low, using the codebase names clk_i and rst_ni.

Behaviour:
- Input sampling: scl_i and sda_i each pass through a 2-flop synchronizer, followed by a third flop used for edge detection.
- Bus conditions, evaluated on the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both take priority over bit handling in the same cycle.
- Bit timing:
  - Input bits are sampled on the detected SCL rising edge, MSB first.
  - sda_oe_o changes only on the detected SCL falling edge, so it is valid 3-4 clk_i after the pad falling edge.
- States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK.
- IDLE: ignore all traffic until a START arrives, then go to DEV_ADDR with the bit counter at 0.
- DEV_ADDR: shift in 8 bits.
  - If bits[7:1] == ADDRESS: go to DEV_ACK and drive ACK (sda_oe_o = 1) for one SCL cycle.
  - Otherwise: leave SDA released (NACK) and go to IDLE.
- After DEV_ACK:
  - R/W = 0: go to WORD_ADDR.
  - R/W = 1: go to RD_DATA.
- WORD_ADDR: shift in 8 bits, load the address pointer, ACK, then go to WR_DATA.
- WR_DATA: shift in 8 bits, write mem[ptr], set ptr = ptr + 1 (8-bit wrap, 0xFF -> 0x00), ACK, repeat.
  - There is no page boundary and no write-busy time; data is readable immediately.
- RD_DATA:
  - Load the shift register with mem[ptr] when entering the state.
  - On each SCL falling edge, drive the current bit: a '0' bit sets sda_oe_o = 1, a '1' bit sets sda_oe_o = 0.
  - After the 8th bit: set ptr = ptr + 1 (wrap), release SDA, go to RD_MACK.
- RD_MACK: sample SDA on the SCL rising edge.
  - 0 (master ACK): go back to RD_DATA with the next byte.
  - 1 (master NACK): go to IDLE.
- Repeated START in any state goes to DEV_ADDR; ptr is kept, which enables random read.
- STOP in any state goes to IDLE and releases SDA on the next clk_i.
- Reset values:
  - state = IDLE, ptr = 0x00, bit counter = 0, sda_oe_o = 0, sda_o = 0.
  - Memory contents are not reset; they persist across rst_ni, as in a nonvolatile device.
  - Asserting reset mid-transfer releases SDA within the same cycle; the bus is then ignored until the next START.
- Write-vs-read collision cannot occur: memory has a single port and one access per byte.

Decomposition:
- Package i2c_eeprom_pkg holds:
  - the state enum type;
  - the default device address constant 7'b1010000;
  - the memory depth constant (256).
- One sub-module, i2c_sync_edge: a 2-flop synchronizer plus edge detector, instantiated for SCL and for SDA. Outputs: level, rise, fall.

Test Plan:
- Byte write then random read:
  - Write 0xA0, 0x10, 0x5A with all ACKs, then STOP.
  - Then send 0xA0, 0x10, repeated START, 0xA1, read one byte, master NACK.
  - Required: 0x5A returned.
- Sequential write with wrap:
  - Write 0xA0, 0xFE, then 0x11 0x22 0x33.
  - Then random-read 3 bytes from 0xFE.
  - Required: 0x11 0x22 0x33 (mem[0x00] = 0x33); current-address read afterwards returns mem[0x01].
- Wrong address: send 0xA2.
  - Required: SDA released at the 9th clock (NACK).
  - Following bytes are ignored and memory is unchanged.
- Master NACK ends a read:
  - Read 2 bytes from 0x10, ACK the first and NACK the second.
  - Required: the slave releases SDA and does not drive any further bits; the pointer ends at 0x12.
- Mid-transfer STOP and reset:
  - Issue a STOP in the middle of a data byte. Required: no memory write, sda_oe_o = 0.
  - Assert rst_ni low while the slave is driving an ACK. Required: sda_oe_o goes to 0 asynchronously, and stored data is preserved.
- Timing check: run SCL at clk_i/8.
  - Required: every slave-driven SDA change occurs while SCL is low.
  - Required: no false START/STOP is detected while the slave drives ACK.
